// File: rtl/ocean_game_sequencer_pkg.sv
// Shared encodings for the ocean game: game states and 12-bit RGB colours
// used by the sequencer and the drawing logic.
package ocean_game_pkg;

    localparam logic [2:0] ST_ATTRACT   = 3'd0;
    localparam logic [2:0] ST_PLAY      = 3'd1;
    localparam logic [2:0] ST_DEAD      = 3'd2;
    localparam logic [2:0] ST_WIN       = 3'd3;
    localparam logic [2:0] ST_GAME_OVER = 3'd4;

    localparam logic [11:0] COL_BLACK  = 12'h000;
    localparam logic [11:0] COL_TURQ   = 12'h0FF;
    localparam logic [11:0] COL_RED    = 12'hF00;
    localparam logic [11:0] COL_WHITE  = 12'hFFF;
    localparam logic [11:0] COL_YELLOW = 12'hFF0;

    localparam logic [11:0] COL_SHARK  = 12'h888;
    localparam logic [11:0] COL_BOTTLE = 12'h0F0;

endpackage

// File: rtl/ocean_game_sequencer_frame_timer.sv
// Loadable 8-bit frame down-counter; done_o is a combinational pulse on the
// frame tick that takes the count from 1 to 0.
module frame_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    input  logic       tick_i,
    output logic       done_o
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (tick_i && (cnt_q != 8'd0)) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = tick_i & ~load_i & (cnt_q == 8'd1);

endmodule

// File: rtl/ocean_game_sequencer.sv
// Ocean game flow controller: samples overlap flags once per frame, keeps
// score and lives, and sequences ATTRACT/PLAY/DEAD/WIN/GAME_OVER.
module ocean_game_sequencer
    import ocean_game_pkg::*;
#(
    parameter int SHARK_N     = 2,
    parameter int BOTTLE_N    = 2,
    parameter int LIVES_INIT  = 3,
    parameter int BOTTLE_GOAL = 8,
    parameter int DEAD_FRAMES = 60
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                frame_tick_i,
    input  logic                start_i,
    input  logic [SHARK_N-1:0]  shark_hit_i,
    input  logic [BOTTLE_N-1:0] bottle_hit_i,
    output logic [2:0]          game_state_o,
    output logic                move_en_o,
    output logic [BOTTLE_N-1:0] bottle_collect_o,
    output logic                respawn_all_o,
    output logic [7:0]          score_o,
    output logic [2:0]          lives_o,
    output logic [11:0]         bg_color_o
);

    logic [2:0]          state_q,   state_d;
    logic [7:0]          score_q,   score_d;
    logic [2:0]          lives_q,   lives_d;
    logic [BOTTLE_N-1:0] collect_q, collect_d;
    logic                respawn_q, respawn_d;
    logic                move_en_q, move_en_d;
    logic [11:0]         bg_q,      bg_d;
    logic                start_q;

    logic       start_rise;
    logic       timer_load;
    logic       timer_tick;
    logic       timer_done;
    logic [2:0] lives_dec;
    logic [8:0] pop;
    logic [8:0] sum9;

    assign start_rise = start_i & ~start_q;
    assign timer_tick = frame_tick_i & (state_q == ST_DEAD);
    assign lives_dec  = lives_q - 3'd1;

    always_comb begin
        pop = 9'd0;
        for (int i = 0; i < BOTTLE_N; i++) begin
            pop = pop + {8'd0, bottle_hit_i[i]};
        end
        sum9 = {1'b0, score_q} + pop;
    end

    always_comb begin
        state_d    = state_q;
        score_d    = score_q;
        lives_d    = lives_q;
        collect_d  = '0;
        respawn_d  = 1'b0;
        timer_load = 1'b0;
        case (state_q)
            ST_ATTRACT: begin
                if (start_rise) begin
                    score_d   = 8'd0;
                    lives_d   = 3'(LIVES_INIT);
                    respawn_d = 1'b1;
                    state_d   = ST_PLAY;
                end
            end
            ST_PLAY: begin
                // A shark hit in a frame wins over any bottle hit in that frame.
                if (frame_tick_i) begin
                    if (|shark_hit_i) begin
                        lives_d = lives_dec;
                        if (lives_dec == 3'd0) begin
                            state_d = ST_GAME_OVER;
                        end else begin
                            state_d    = ST_DEAD;
                            timer_load = 1'b1;
                        end
                    end else if (|bottle_hit_i) begin
                        collect_d = bottle_hit_i;
                        score_d   = sum9[8] ? 8'hFF : sum9[7:0];
                        if (score_d >= 8'(BOTTLE_GOAL)) begin
                            state_d = ST_WIN;
                        end
                    end
                end
            end
            ST_DEAD: begin
                if (timer_done) begin
                    respawn_d = 1'b1;
                    state_d   = ST_PLAY;
                end
            end
            ST_WIN, ST_GAME_OVER: begin
                if (start_rise) begin
                    state_d = ST_ATTRACT;
                end
            end
            default: state_d = ST_ATTRACT;
        endcase
    end

    always_comb begin
        move_en_d = (state_d == ST_PLAY);
        case (state_d)
            ST_PLAY:      bg_d = COL_TURQ;
            ST_DEAD:      bg_d = COL_RED;
            ST_WIN:       bg_d = COL_WHITE;
            ST_GAME_OVER: bg_d = COL_YELLOW;
            default:      bg_d = COL_BLACK;
        endcase
    end

    frame_timer u_dead_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (timer_load),
        .load_val_i (8'(DEAD_FRAMES)),
        .tick_i     (timer_tick),
        .done_o     (timer_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_ATTRACT;
            score_q   <= 8'd0;
            lives_q   <= 3'(LIVES_INIT);
            collect_q <= '0;
            respawn_q <= 1'b0;
            move_en_q <= 1'b0;
            bg_q      <= COL_BLACK;
            start_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            score_q   <= score_d;
            lives_q   <= lives_d;
            collect_q <= collect_d;
            respawn_q <= respawn_d;
            move_en_q <= move_en_d;
            bg_q      <= bg_d;
            start_q   <= start_i;
        end
    end

    assign game_state_o     = state_q;
    assign move_en_o        = move_en_q;
    assign bottle_collect_o = collect_q;
    assign respawn_all_o    = respawn_q;
    assign score_o          = score_q;
    assign lives_o          = lives_q;
    assign bg_color_o       = bg_q;

endmodule
